fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_N         = 32;
    localparam int DEF_MAX_BURST = 4;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin winner search: first requester after last_owner, wrapping.
module rr_pick
    import fifo_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int OW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   last_owner,
    output logic [OW-1:0]   winner,
    output logic            valid
);

    // Scan from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_owner) + k) % NREQ;
            if (req[idx]) begin
                winner = idx[OW-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between NREQ requesters with bounded,
// round-robin burst tenures and an idle bubble between tenures.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int NREQ      = DEF_NREQ,
    parameter  int N         = DEF_N,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int OW        = idx_w(NREQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] wdata_in,
    output logic [NREQ-1:0]   gnt,
    input  logic              fifo_full,
    output logic              fifo_wen,
    output logic [N-1:0]      fifo_wdata,
    output logic [OW-1:0]     owner,
    output logic              busy
);

    state_t         state_q, state_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic [OW-1:0]  last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [OW-1:0]  pick_idx;
    logic           pick_valid;
    logic           accept;
    logic           req_own;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req        (req),
        .last_owner (last_q),
        .winner     (pick_idx),
        .valid      (pick_valid)
    );

    // Grant only the owner, and only when the FIFO can take the beat.
    always_comb begin
        gnt = '0;
        if (state_q == BURST && !fifo_full) gnt[owner_q] = 1'b1;
    end

    assign accept   = |(req & gnt);
    assign fifo_wen = accept;
    assign req_own  = req[owner_q];
    assign owner    = owner_q;
    assign busy     = (state_q == BURST);

    // Write data is the accepted requester's slice, zero when nothing is written.
    always_comb begin
        fifo_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && gnt[i]) fifo_wdata = wdata_in[i*N +: N];
        end
    end

    // Tenure control: arbitrate in IDLE, count beats in BURST, leave on drop or cap.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BURST;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (!req_own) begin
                    // Owner gave up: forfeit the rest of the tenure.
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
                // fifo_full with req held: everything holds.
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last_owner resets to NREQ-1 so requester 0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
